// File: rtl/tlb_op_ctrl_pkg.sv
// Shared CPU defines for the TLB instruction controller: op encoding and FSM states.
package tlb_op_ctrl_pkg;

  localparam int unsigned TLBNUM_DEF = 16;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } tlb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PROBE    = 3'd1,
    ST_PROBE_WB = 3'd2,
    ST_READ     = 3'd3,
    ST_READ_WB  = 3'd4,
    ST_WRITE    = 3'd5,
    ST_FLUSH    = 3'd6
  } tlb_state_t;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Pipeline/TLB/CP0 signal bundle around the TLB instruction controller.
interface tlb_op_ctrl_if
  import tlb_op_ctrl_pkg::*;
#(
  parameter int unsigned IW = 4
);
  logic          op_valid;
  tlb_op_t       op_type;
  logic          op_done;
  logic          busy;
  logic          dmem_req;
  logic          dmem_grant;
  logic          s1_probe_sel;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic [IW-1:0] cp0_index;
  logic [IW-1:0] tlb_r_index;
  logic [IW-1:0] tlb_w_index;
  logic          tlb_we;
  logic          cp0_p_wr;
  logic          cp0_p_notfound;
  logic [IW-1:0] cp0_p_index;
  logic          cp0_r_wr;
  logic          flush_req;
  logic          flush_ack;

  // Controller side.
  modport slave (
    input  op_valid, op_type, dmem_req, s1_found, s1_index, cp0_index, flush_ack,
    output op_done, busy, dmem_grant, s1_probe_sel, tlb_r_index, tlb_w_index,
           tlb_we, cp0_p_wr, cp0_p_notfound, cp0_p_index, cp0_r_wr, flush_req
  );

  // Pipeline / TLB / CP0 side.
  modport master (
    output op_valid, op_type, dmem_req, s1_found, s1_index, cp0_index, flush_ack,
    input  op_done, busy, dmem_grant, s1_probe_sel, tlb_r_index, tlb_w_index,
           tlb_we, cp0_p_wr, cp0_p_notfound, cp0_p_index, cp0_r_wr, flush_req
  );

endinterface

// File: rtl/tlb_rand_cnt.sv
// Free-running down counter supplying the TLBWR replacement index.
module tlb_rand_cnt #(
  parameter int unsigned TLBNUM = 16,
  localparam int unsigned IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] count
);

  logic [IW-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == '0) ? IW'(TLBNUM - 1) : count_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= IW'(TLBNUM - 1);
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR: shares search port s1 with data translation,
// writes probe/read results back to CP0 and requests a refetch flush after writes.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = TLBNUM_DEF,
  localparam int unsigned IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  tlb_op_ctrl_if.slave  bus
);

  tlb_state_t    state_q, state_d;
  logic [IW-1:0] w_idx_q, w_idx_d;
  logic [IW-1:0] p_idx_q, p_idx_d;
  logic          found_q, found_d;
  logic [IW-1:0] rand_cnt;

  tlb_rand_cnt #(.TLBNUM(TLBNUM)) u_rand (
    .clk   (clk),
    .rst   (rst),
    .count (rand_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_idx_q <= '0;
      p_idx_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_idx_q <= w_idx_d;
      p_idx_q <= p_idx_d;
      found_q <= found_d;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d            = state_q;
    w_idx_d            = w_idx_q;
    p_idx_d            = p_idx_q;
    found_d            = found_q;
    bus.op_done        = 1'b0;
    bus.busy           = (state_q != ST_IDLE) || bus.op_valid;
    bus.dmem_grant     = bus.dmem_req;
    bus.s1_probe_sel   = 1'b0;
    bus.tlb_r_index    = '0;
    bus.tlb_w_index    = '0;
    bus.tlb_we         = 1'b0;
    bus.cp0_p_wr       = 1'b0;
    bus.cp0_p_notfound = 1'b0;
    bus.cp0_p_index    = '0;
    bus.cp0_r_wr       = 1'b0;
    bus.flush_req      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          unique case (bus.op_type)
            OP_TLBP:  state_d = ST_PROBE;
            OP_TLBR:  state_d = ST_READ;
            OP_TLBWI: begin
              w_idx_d = bus.cp0_index;
              state_d = ST_WRITE;
            end
            OP_TLBWR: begin
              w_idx_d = rand_cnt;
              state_d = ST_WRITE;
            end
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_PROBE: begin
        bus.s1_probe_sel = 1'b1;
        bus.dmem_grant   = 1'b0;
        found_d          = bus.s1_found;
        p_idx_d          = bus.s1_index;
        state_d          = ST_PROBE_WB;
      end
      ST_PROBE_WB: begin
        bus.cp0_p_wr       = 1'b1;
        bus.cp0_p_notfound = ~found_q;
        bus.cp0_p_index    = p_idx_q;
        bus.op_done        = 1'b1;
        state_d            = ST_IDLE;
      end
      ST_READ: begin
        bus.tlb_r_index = bus.cp0_index;
        state_d         = ST_READ_WB;
      end
      ST_READ_WB: begin
        bus.cp0_r_wr = 1'b1;
        bus.op_done  = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_WRITE: begin
        bus.tlb_we      = 1'b1;
        bus.tlb_w_index = w_idx_q;
        state_d         = ST_FLUSH;
      end
      ST_FLUSH: begin
        bus.flush_req = 1'b1;
        if (bus.flush_ack) begin
          bus.op_done = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset cycle kills every strobe so an aborted op leaves no side effects.
    if (rst) begin
      bus.op_done        = 1'b0;
      bus.busy           = 1'b0;
      bus.s1_probe_sel   = 1'b0;
      bus.tlb_r_index    = '0;
      bus.tlb_w_index    = '0;
      bus.tlb_we         = 1'b0;
      bus.cp0_p_wr       = 1'b0;
      bus.cp0_p_notfound = 1'b0;
      bus.cp0_p_index    = '0;
      bus.cp0_r_wr       = 1'b0;
      bus.flush_req      = 1'b0;
      bus.dmem_grant     = bus.dmem_req;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: per-cycle transaction model plus directed literal checks.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  tlb_op_ctrl_if #(.IW(4)) b ();

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: op in flight, cycles since acceptance, cycles since reset.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  int         m_cnt    = 0;
  tlb_op_t    m_op     = OP_TLBP;
  logic [3:0] m_widx   = '0;
  logic [3:0] m_pidx   = '0;
  logic       m_found  = 1'b0;

  logic       e_grant, e_busy, e_done, e_psel, e_pwr, e_pnf, e_rwr, e_we, e_freq;
  logic [3:0] e_pidx, e_ridx, e_widx;

  always @(negedge clk) begin
    if (chk_en) begin
      e_grant = b.dmem_req; e_busy = 1'b0; e_done = 1'b0; e_psel = 1'b0;
      e_pwr = 1'b0; e_pnf = 1'b0; e_rwr = 1'b0; e_we = 1'b0; e_freq = 1'b0;
      e_pidx = '0; e_ridx = '0; e_widx = '0;
      if (rst) begin
        m_active = 1'b0;
        m_cnt    = 0;
      end else begin
        if (!m_active) begin
          e_busy = b.op_valid;
          if (b.op_valid) begin
            m_active = 1'b1;
            m_k      = 1;
            m_op     = b.op_type;
            m_widx   = (b.op_type == OP_TLBWI) ? b.cp0_index : 4'(15 - (m_cnt % 16));
          end
        end else begin
          e_busy = 1'b1;
          if (m_k == 1) begin
            case (m_op)
              OP_TLBP: begin
                e_psel = 1'b1; e_grant = 1'b0;
                m_found = b.s1_found; m_pidx = b.s1_index;
              end
              OP_TLBR: e_ridx = b.cp0_index;
              default: begin e_we = 1'b1; e_widx = m_widx; end
            endcase
          end else begin
            case (m_op)
              OP_TLBP: begin
                e_pwr = 1'b1; e_pnf = ~m_found; e_pidx = m_pidx;
                e_done = 1'b1; m_active = 1'b0;
              end
              OP_TLBR: begin e_rwr = 1'b1; e_done = 1'b1; m_active = 1'b0; end
              default: begin
                e_freq = 1'b1;
                if (b.flush_ack) begin e_done = 1'b1; m_active = 1'b0; end
              end
            endcase
          end
          m_k++;
        end
        m_cnt++;
      end
      chk("m_grant",   b.dmem_grant,     e_grant);
      chk("m_busy",    b.busy,           e_busy);
      chk("m_done",    b.op_done,        e_done);
      chk("m_psel",    b.s1_probe_sel,   e_psel);
      chk("m_pwr",     b.cp0_p_wr,       e_pwr);
      chk("m_pnf",     b.cp0_p_notfound, e_pnf);
      chk("m_pidx",    b.cp0_p_index,    e_pidx);
      chk("m_rwr",     b.cp0_r_wr,       e_rwr);
      chk("m_ridx",    b.tlb_r_index,    e_ridx);
      chk("m_we",      b.tlb_we,         e_we);
      chk("m_widx",    b.tlb_w_index,    e_widx);
      chk("m_freq",    b.flush_req,      e_freq);
    end
  end

  // Ends in the first cycle after reset release (random count = 15).
  task automatic reset_dut();
    rst = 1'b1;
    b.op_valid = 1'b0;
    b.flush_ack = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Holds op_valid until op_done; flush_ack rises ack_delay cycles into FLUSH.
  task automatic run_op(input tlb_op_t t, input int ack_delay, output int lat,
                        output int n_we, output int n_freq,
                        output logic [3:0] widx, output logic [3:0] ridx);
    bit done = 1'b0;
    lat = 0; n_we = 0; n_freq = 0; widx = '0; ridx = '0;
    b.op_valid = 1'b1;
    b.op_type  = t;
    for (int c = 1; c <= 24 && !done; c++) begin
      b.flush_ack = (c == 2 + ack_delay);
      b.dmem_req  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b.tlb_we) begin n_we++; widx = b.tlb_w_index; end
      if (b.flush_req) n_freq++;
      if (c == 2) ridx = b.tlb_r_index;
      if (b.op_done) begin lat = c; done = 1'b1; end
      cyc();
    end
    b.op_valid  = 1'b0;
    b.flush_ack = 1'b0;
    if (!done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  int         lat, nwe, nfr;
  logic [3:0] widx, ridx;

  initial begin
    rst = 1'b1;
    b.op_valid = 1'b0; b.op_type = OP_TLBP; b.dmem_req = 1'b0;
    b.s1_found = 1'b0; b.s1_index = '0; b.cp0_index = '0; b.flush_ack = 1'b0;
    cyc();
    chk_en = 1'b1;
    reset_dut();

    @(negedge clk);
    chk("idle_busy", b.busy, 0);
    chk("idle_done", b.op_done, 0);
    cyc();

    // TLBP hit with data side requesting every cycle.
    b.dmem_req = 1'b1; b.op_valid = 1'b1; b.op_type = OP_TLBP;
    b.s1_found = 1'b1; b.s1_index = 4'd5;
    @(negedge clk);
    chk("p_acc_busy", b.busy, 1);
    chk("p_acc_grant", b.dmem_grant, 1);
    cyc();
    @(negedge clk);
    chk("p_probe_grant", b.dmem_grant, 0);
    chk("p_probe_sel", b.s1_probe_sel, 1);
    cyc();
    @(negedge clk);
    chk("p_done", b.op_done, 1);
    chk("p_wr", b.cp0_p_wr, 1);
    chk("p_notfound", b.cp0_p_notfound, 0);
    chk("p_index", b.cp0_p_index, 5);
    chk("p_wb_grant", b.dmem_grant, 1);
    cyc();
    b.op_valid = 1'b0;
    @(negedge clk);
    chk("p_after_done", b.op_done, 0);
    chk("p_after_busy", b.busy, 0);
    cyc();

    // TLBP miss.
    b.s1_found = 1'b0; b.s1_index = 4'd7;
    run_op(OP_TLBP, 0, lat, nwe, nfr, widx, ridx);
    chk("p_miss_lat", lat, 3);

    // TLBR.
    b.cp0_index = 4'd9;
    run_op(OP_TLBR, 0, lat, nwe, nfr, widx, ridx);
    chk("r_lat", lat, 3);
    chk("r_index", ridx, 9);
    chk("r_no_we", nwe, 0);

    // TLBWI with a four-cycle flush wait.
    b.cp0_index = 4'd3;
    run_op(OP_TLBWI, 4, lat, nwe, nfr, widx, ridx);
    chk("wi_lat", lat, 6);
    chk("wi_we_count", nwe, 1);
    chk("wi_windex", widx, 3);
    chk("wi_flush_cycles", nfr, 4);

    // TLBWR accepted 5 cycles after reset.
    reset_dut();
    repeat (5) cyc();
    run_op(OP_TLBWR, 1, lat, nwe, nfr, widx, ridx);
    chk("wr5_windex", widx, 10);
    chk("wr5_lat", lat, 3);

    // Counter reaches 0 at cycle 15 and wraps to 15 at cycle 16.
    reset_dut();
    repeat (15) cyc();
    run_op(OP_TLBWR, 1, lat, nwe, nfr, widx, ridx);
    chk("wr15_windex", widx, 0);
    reset_dut();
    repeat (16) cyc();
    run_op(OP_TLBWR, 1, lat, nwe, nfr, widx, ridx);
    chk("wr16_windex", widx, 15);

    // Reset landing in the WRITE cycle aborts the op.
    reset_dut();
    b.cp0_index = 4'd6; b.op_valid = 1'b1; b.op_type = OP_TLBWI;
    cyc();
    rst = 1'b1;
    b.op_valid = 1'b0;
    @(negedge clk);
    chk("rstw_we", b.tlb_we, 0);
    chk("rstw_done", b.op_done, 0);
    cyc();
    rst = 1'b0;
    b.flush_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstw_after_we", b.tlb_we, 0);
      chk("rstw_after_done", b.op_done, 0);
      chk("rstw_after_freq", b.flush_req, 0);
      chk("rstw_state", 32'(dut.state_q), 32'(ST_IDLE));
      cyc();
    end
    b.flush_ack = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
